// File: rtl/render_pkg.sv
// Shared render-pipeline types: culler FSM states and the area-width helper.
package render_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SUB,
    MUL,
    CLASSIFY,
    OUT
  } cull_state_t;

  function automatic int area_width(input int dw);
    return 2 * dw + 3;
  endfunction

endpackage

// File: rtl/tri_bbox_clamp.sv
// Min/max of three signed coordinates on one axis, plus the same range clamped to 0..LIMIT-1.
module tri_bbox_clamp #(
  parameter int DATAWIDTH = 12,
  parameter int LIMIT     = 320
) (
  input  logic signed [DATAWIDTH-1:0] i_a,
  input  logic signed [DATAWIDTH-1:0] i_b,
  input  logic signed [DATAWIDTH-1:0] i_c,
  output logic signed [DATAWIDTH-1:0] o_raw_min,
  output logic signed [DATAWIDTH-1:0] o_raw_max,
  output logic signed [DATAWIDTH-1:0] o_clamp_min,
  output logic signed [DATAWIDTH-1:0] o_clamp_max
);

  localparam logic signed [DATAWIDTH-1:0] HI = DATAWIDTH'(LIMIT - 1);

  logic signed [DATAWIDTH-1:0] lo_c;
  logic signed [DATAWIDTH-1:0] hi_c;

  always_comb begin
    lo_c = i_a;
    hi_c = i_a;
    if (i_b < lo_c) lo_c = i_b;
    if (i_c < lo_c) lo_c = i_c;
    if (i_b > hi_c) hi_c = i_b;
    if (i_c > hi_c) hi_c = i_c;
  end

  // Only the low side of min and the high side of max can leave the screen on a survivor.
  assign o_raw_min   = lo_c;
  assign o_raw_max   = hi_c;
  assign o_clamp_min = lo_c[DATAWIDTH-1] ? '0 : lo_c;
  assign o_clamp_max = (hi_c > HI) ? HI : hi_c;

endmodule

// File: rtl/primitive_culler.sv
// Triangle setup/cull: doubled signed area, clamped bbox, drops degenerate/off-screen triangles.
// Define BACKFACE_CULL_EN to also drop negative-area (clockwise) triangles.
module primitive_culler
  import render_pkg::*;
#(
  parameter  int DATAWIDTH     = 12,
  parameter  int SCREEN_WIDTH  = 320,
  parameter  int SCREEN_HEIGHT = 320,
  localparam int AREA_W        = area_width(DATAWIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        o_ready,
  input  logic signed [DATAWIDTH-1:0] i_v0 [3],
  input  logic signed [DATAWIDTH-1:0] i_v1 [3],
  input  logic signed [DATAWIDTH-1:0] i_v2 [3],
  input  logic                        i_dv,
  input  logic                        i_last,
  input  logic                        i_ready,
  output logic signed [DATAWIDTH-1:0] o_v0 [3],
  output logic signed [DATAWIDTH-1:0] o_v1 [3],
  output logic signed [DATAWIDTH-1:0] o_v2 [3],
  output logic signed [DATAWIDTH-1:0] o_bb_min_x,
  output logic signed [DATAWIDTH-1:0] o_bb_max_x,
  output logic signed [DATAWIDTH-1:0] o_bb_min_y,
  output logic signed [DATAWIDTH-1:0] o_bb_max_y,
  output logic signed [AREA_W-1:0]    o_area,
  output logic                        o_dv,
  output logic                        o_last,
  output logic                        o_finished
);

  localparam int DW = DATAWIDTH;
  localparam int PW = 2 * DATAWIDTH + 2;
  localparam logic signed [DW-1:0] X_HI = DW'(SCREEN_WIDTH - 1);
  localparam logic signed [DW-1:0] Y_HI = DW'(SCREEN_HEIGHT - 1);

  function automatic logic signed [DW:0] sext(input logic signed [DW-1:0] a);
    return {a[DW-1], a};
  endfunction

  cull_state_t state_q, state_d;

  logic signed [DW-1:0] v0_q [3], v0_d [3];
  logic signed [DW-1:0] v1_q [3], v1_d [3];
  logic signed [DW-1:0] v2_q [3], v2_d [3];
  logic                 last_q, last_d;
  logic signed [DW:0]   dx1_q, dx1_d, dy1_q, dy1_d, dx2_q, dx2_d, dy2_q, dy2_d;
  logic signed [DW-1:0] minx_q, minx_d, maxx_q, maxx_d, miny_q, miny_d, maxy_q, maxy_d;
  logic signed [PW-1:0] p0_q, p0_d, p1_q, p1_d;
  logic signed [DW-1:0] bbx0_q, bbx0_d, bbx1_q, bbx1_d, bby0_q, bby0_d, bby1_q, bby1_d;
  logic signed [AREA_W-1:0] area_q, area_d, area_c;
  logic                 dv_q, dv_d, olast_q, olast_d, fin_q, fin_d;
  logic                 cull_c;

  logic signed [DW-1:0] rminx_c, rmaxx_c, rminy_c, rmaxy_c;
  logic signed [DW-1:0] cminx_c, cmaxx_c, cminy_c, cmaxy_c;

  tri_bbox_clamp #(.DATAWIDTH(DW), .LIMIT(SCREEN_WIDTH)) u_bbox_x (
    .i_a(v0_q[0]), .i_b(v1_q[0]), .i_c(v2_q[0]),
    .o_raw_min(rminx_c), .o_raw_max(rmaxx_c),
    .o_clamp_min(cminx_c), .o_clamp_max(cmaxx_c)
  );

  tri_bbox_clamp #(.DATAWIDTH(DW), .LIMIT(SCREEN_HEIGHT)) u_bbox_y (
    .i_a(v0_q[1]), .i_b(v1_q[1]), .i_c(v2_q[1]),
    .o_raw_min(rminy_c), .o_raw_max(rmaxy_c),
    .o_clamp_min(cminy_c), .o_clamp_max(cmaxy_c)
  );

  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    last_d  = last_q;
    dx1_d   = dx1_q;
    dy1_d   = dy1_q;
    dx2_d   = dx2_q;
    dy2_d   = dy2_q;
    minx_d  = minx_q;
    maxx_d  = maxx_q;
    miny_d  = miny_q;
    maxy_d  = maxy_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    bbx0_d  = bbx0_q;
    bbx1_d  = bbx1_q;
    bby0_d  = bby0_q;
    bby1_d  = bby1_q;
    area_d  = area_q;
    dv_d    = dv_q;
    olast_d = olast_q;
    fin_d   = 1'b0;

    // Products are 2*DW+2 wide, so their difference cannot overflow AREA_W.
    area_c = AREA_W'(p0_q) - AREA_W'(p1_q);
    cull_c = (area_c == '0) || maxx_q[DW-1] || (minx_q > X_HI) ||
             maxy_q[DW-1] || (miny_q > Y_HI);
`ifdef BACKFACE_CULL_EN
    cull_c = cull_c || area_c[AREA_W-1];
`endif

    unique case (state_q)
      IDLE: begin
        if (i_dv) begin
          v0_d    = i_v0;
          v1_d    = i_v1;
          v2_d    = i_v2;
          last_d  = i_last;
          state_d = SUB;
        end
      end
      SUB: begin
        dx1_d   = sext(v1_q[0]) - sext(v0_q[0]);
        dy1_d   = sext(v1_q[1]) - sext(v0_q[1]);
        dx2_d   = sext(v2_q[0]) - sext(v0_q[0]);
        dy2_d   = sext(v2_q[1]) - sext(v0_q[1]);
        minx_d  = rminx_c;
        maxx_d  = rmaxx_c;
        miny_d  = rminy_c;
        maxy_d  = rmaxy_c;
        state_d = MUL;
      end
      MUL: begin
        p0_d    = PW'(dx1_q) * PW'(dy2_q);
        p1_d    = PW'(dx2_q) * PW'(dy1_q);
        bbx0_d  = cminx_c;
        bbx1_d  = cmaxx_c;
        bby0_d  = cminy_c;
        bby1_d  = cmaxy_c;
        state_d = CLASSIFY;
      end
      CLASSIFY: begin
        area_d = area_c;
        if (cull_c) begin
          fin_d   = last_q;
          state_d = IDLE;
        end else begin
          dv_d    = 1'b1;
          olast_d = last_q;
          state_d = OUT;
        end
      end
      OUT: begin
        if (i_ready) begin
          dv_d    = 1'b0;
          olast_d = 1'b0;
          fin_d   = olast_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Everything visible on the output ports is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v0_q    <= '{default: '0};
      v1_q    <= '{default: '0};
      v2_q    <= '{default: '0};
      last_q  <= 1'b0;
      bbx0_q  <= '0;
      bbx1_q  <= '0;
      bby0_q  <= '0;
      bby1_q  <= '0;
      area_q  <= '0;
      dv_q    <= 1'b0;
      olast_q <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      last_q  <= last_d;
      bbx0_q  <= bbx0_d;
      bbx1_q  <= bbx1_d;
      bby0_q  <= bby0_d;
      bby1_q  <= bby1_d;
      area_q  <= area_d;
      dv_q    <= dv_d;
      olast_q <= olast_d;
      fin_q   <= fin_d;
    end
  end

  always_ff @(posedge clk) begin
    dx1_q  <= dx1_d;
    dy1_q  <= dy1_d;
    dx2_q  <= dx2_d;
    dy2_q  <= dy2_d;
    minx_q <= minx_d;
    maxx_q <= maxx_d;
    miny_q <= miny_d;
    maxy_q <= maxy_d;
    p0_q   <= p0_d;
    p1_q   <= p1_d;
  end

  assign o_ready    = (state_q == IDLE);
  assign o_v0       = v0_q;
  assign o_v1       = v1_q;
  assign o_v2       = v2_q;
  assign o_bb_min_x = bbx0_q;
  assign o_bb_max_x = bbx1_q;
  assign o_bb_min_y = bby0_q;
  assign o_bb_max_y = bby1_q;
  assign o_area     = area_q;
  assign o_dv       = dv_q;
  assign o_last     = olast_q;
  assign o_finished = fin_q;

endmodule

// File: tb/tb_primitive_culler.sv
// Directed bench for primitive_culler: latency, area/bbox results, culling, backpressure, reset.
module tb_primitive_culler;

  localparam int DW = 12;
  localparam int AW = 2 * DW + 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 o_ready;
  logic signed [DW-1:0] i_v0 [3];
  logic signed [DW-1:0] i_v1 [3];
  logic signed [DW-1:0] i_v2 [3];
  logic                 i_dv, i_last, i_ready;
  logic signed [DW-1:0] o_v0 [3];
  logic signed [DW-1:0] o_v1 [3];
  logic signed [DW-1:0] o_v2 [3];
  logic signed [DW-1:0] o_bb_min_x, o_bb_max_x, o_bb_min_y, o_bb_max_y;
  logic signed [AW-1:0] o_area;
  logic                 o_dv, o_last, o_finished;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int v [3][3];
    int area;
    int bx0, bx1, by0, by1;
    bit last;
  } exp_t;

  exp_t sb [$];

  primitive_culler #(.DATAWIDTH(DW), .SCREEN_WIDTH(320), .SCREEN_HEIGHT(320)) dut (
    .clk(clk), .rst(rst), .o_ready(o_ready),
    .i_v0(i_v0), .i_v1(i_v1), .i_v2(i_v2),
    .i_dv(i_dv), .i_last(i_last), .i_ready(i_ready),
    .o_v0(o_v0), .o_v1(o_v1), .o_v2(o_v2),
    .o_bb_min_x(o_bb_min_x), .o_bb_max_x(o_bb_max_x),
    .o_bb_min_y(o_bb_min_y), .o_bb_max_y(o_bb_max_y),
    .o_area(o_area), .o_dv(o_dv), .o_last(o_last), .o_finished(o_finished)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_out(input exp_t e);
    for (int c = 0; c < 3; c++) begin
      chk("o_v0", 64'(o_v0[c]), 64'(e.v[0][c]));
      chk("o_v1", 64'(o_v1[c]), 64'(e.v[1][c]));
      chk("o_v2", 64'(o_v2[c]), 64'(e.v[2][c]));
    end
    chk("o_area", 64'(o_area), 64'(e.area));
    chk("bb_min_x", 64'(o_bb_min_x), 64'(e.bx0));
    chk("bb_max_x", 64'(o_bb_max_x), 64'(e.bx1));
    chk("bb_min_y", 64'(o_bb_min_y), 64'(e.by0));
    chk("bb_max_y", 64'(o_bb_max_y), 64'(e.by1));
    chk("o_last", 64'(o_last), 64'(e.last));
    chk("fin_with_dv", 64'(o_finished), 64'(0));
  endtask

  // Drives one triangle at a sample point (1 time unit after an edge) and follows it to completion.
  task automatic run_tri(input int x0, y0, z0, x1, y1, z1, x2, y2, z2,
                         input bit last, input bit emit,
                         input int area, bx0, bx1, by0, by1, input int hold);
    exp_t e, got;
    chk("ready_before", 64'(o_ready), 64'(1));
    e.v  = '{'{x0, y0, z0}, '{x1, y1, z1}, '{x2, y2, z2}};
    e.area = area;
    e.bx0 = bx0; e.bx1 = bx1; e.by0 = by0; e.by1 = by1;
    e.last = last;
    i_v0 = '{DW'(x0), DW'(y0), DW'(z0)};
    i_v1 = '{DW'(x1), DW'(y1), DW'(z1)};
    i_v2 = '{DW'(x2), DW'(y2), DW'(z2)};
    i_last  = last;
    i_dv    = 1'b1;
    i_ready = (hold == 0);
    if (emit) sb.push_back(e);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        i_dv   = 1'b0;
        i_last = 1'b0;
      end
      if (k < 4) begin
        chk("busy_dv", 64'(o_dv), 64'(0));
        chk("busy_ready", 64'(o_ready), 64'(0));
      end
    end
    chk("lat_dv", 64'(o_dv), 64'(emit));
    chk("lat_ready", 64'(o_ready), 64'(!emit));
    if (!emit) begin
      chk("cull_last", 64'(o_last), 64'(0));
      chk("cull_fin", 64'(o_finished), 64'(last));
      @(posedge clk); #1;
      chk("fin_one_cycle", 64'(o_finished), 64'(0));
      chk("cull_no_dv", 64'(o_dv), 64'(0));
    end else begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        got = sb.pop_front();
        check_out(got);
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
          chk("hold_dv", 64'(o_dv), 64'(1));
          chk("hold_ready", 64'(o_ready), 64'(0));
          check_out(got);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        chk("xfer_dv", 64'(o_dv), 64'(0));
        chk("xfer_last", 64'(o_last), 64'(0));
        chk("xfer_ready", 64'(o_ready), 64'(1));
        chk("xfer_fin", 64'(o_finished), 64'(got.last));
        @(posedge clk); #1;
        chk("fin_one_cycle", 64'(o_finished), 64'(0));
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int c = 0; c < 3; c++) begin
      chk({tag, "_v0"}, 64'(o_v0[c]), 64'(0));
      chk({tag, "_v1"}, 64'(o_v1[c]), 64'(0));
      chk({tag, "_v2"}, 64'(o_v2[c]), 64'(0));
    end
    chk({tag, "_area"}, 64'(o_area), 64'(0));
    chk({tag, "_bbx0"}, 64'(o_bb_min_x), 64'(0));
    chk({tag, "_bbx1"}, 64'(o_bb_max_x), 64'(0));
    chk({tag, "_bby0"}, 64'(o_bb_min_y), 64'(0));
    chk({tag, "_bby1"}, 64'(o_bb_max_y), 64'(0));
    chk({tag, "_dv"}, 64'(o_dv), 64'(0));
    chk({tag, "_last"}, 64'(o_last), 64'(0));
    chk({tag, "_fin"}, 64'(o_finished), 64'(0));
    chk({tag, "_ready"}, 64'(o_ready), 64'(1));
  endtask

  initial begin
    rst     = 1'b1;
    i_dv    = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    i_v0    = '{default: '0};
    i_v1    = '{default: '0};
    i_v2    = '{default: '0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero_outputs("reset");

    // Counter-clockwise right triangle, z passed through.
    run_tri(10, 10, 5, 50, 10, 6, 10, 50, 7, 0, 1, 1600, 10, 50, 10, 50, 0);

    // Same triangle with opposite winding.
`ifdef BACKFACE_CULL_EN
    run_tri(10, 10, 5, 10, 50, 7, 50, 10, 6, 0, 0, 0, 0, 0, 0, 0, 0);
`else
    run_tri(10, 10, 5, 10, 50, 7, 50, 10, 6, 0, 1, -1600, 10, 50, 10, 50, 0);
`endif

    // Degenerate and off-screen triangles.
    run_tri(0, 0, 1, 10, 10, 2, 20, 20, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    run_tri(-30, -5, 0, -10, -5, 0, -20, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_tri(330, 10, 0, 400, 10, 0, 330, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_tri(10, 330, 0, 50, 330, 0, 10, 360, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Touches the right screen edge only: survives with a one-column bbox.
    run_tri(319, 0, 4, 400, 0, 4, 319, 40, 4, 0, 1, 3240, 319, 319, 0, 40, 0);

    // Large triangle clamped on all four sides.
    run_tri(-20, -20, 9, 400, 10, 8, 10, 400, 7, 0, 1, 175500, 0, 319, 0, 319, 0);

    // Backpressure for five cycles on a last triangle, then a culled last triangle.
    run_tri(10, 10, 5, 50, 10, 6, 10, 50, 7, 1, 1, 1600, 10, 50, 10, 50, 5);
    run_tri(0, 0, 0, 10, 10, 0, 20, 20, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Reset while the triangle is in MUL drops it without any trace.
    chk("pre_rst_ready", 64'(o_ready), 64'(1));
    i_v0   = '{DW'(10), DW'(10), DW'(5)};
    i_v1   = '{DW'(50), DW'(10), DW'(6)};
    i_v2   = '{DW'(10), DW'(50), DW'(7)};
    i_last = 1'b1;
    i_dv   = 1'b1;
    @(posedge clk); #1;
    i_dv   = 1'b0;
    i_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero_outputs("mid_rst");
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      chk("post_rst_dv", 64'(o_dv), 64'(0));
      chk("post_rst_fin", 64'(o_finished), 64'(0));
      chk("post_rst_ready", 64'(o_ready), 64'(1));
    end

    // A fresh triangle after the aborted one behaves normally.
    run_tri(10, 10, 5, 50, 10, 6, 10, 50, 7, 0, 1, 1600, 10, 50, 10, 50, 0);

    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
